// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dm_lsu
// Purpose  : Load/store sequencer for a synchronous data memory with a
//            one-cycle registered read. It aligns and extends load data and
//            merges sub-word stores into the word that is read back.
// Revision : 1.0  initial release
// ============================================================================
module dm_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writedata,
    output logic        mem_we,
    input  logic [31:0] mem_readdata
);

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;
    localparam logic [1:0] C_SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic        w_bad;
    logic [31:0] w_shifted;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_bad = (req_size == C_SZ_ILL)
                || (req_size == C_SZ_HALF && req_addr[0])
                || (req_size == C_SZ_WORD && req_addr[1:0] != 2'b00);

    assign w_shifted = mem_readdata >> {r_lane, 3'b000};
    assign w_half    = r_lane[1] ? mem_readdata[31:16] : mem_readdata[15:0];

    always_comb begin
        w_load = mem_readdata;
        case (r_size)
            C_SZ_BYTE: w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            C_SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default:   w_load = mem_readdata;
        endcase
    end

    // Store bytes overwrite only their own lane of the word just read back.
    always_comb begin
        w_merge = mem_readdata;
        case (r_size)
            C_SZ_BYTE: w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
            C_SZ_HALF: begin
                if (r_lane[1]) w_merge[31:16] = r_wdata;
                else           w_merge[15:0]  = r_wdata;
            end
            default:   w_merge = mem_readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_we          <= 1'b0;
            r_signed      <= 1'b0;
            r_size        <= 2'b00;
            r_lane        <= 2'b00;
            r_wdata       <= 16'h0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 32'h0;
            rsp_err       <= 1'b0;
            mem_addr      <= 32'h0;
            mem_writedata <= 32'h0;
            mem_we        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            mem_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_signed  <= req_signed;
                        r_size    <= req_size;
                        r_lane    <= req_addr[1:0];
                        r_wdata   <= req_wdata[15:0];
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b0;
                        if (w_bad) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_we && req_size == C_SZ_WORD) begin
                                mem_writedata <= req_wdata;
                                mem_we        <= 1'b1;
                                r_state       <= S_WR;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD:  r_state <= S_RDW;
                S_RDW: begin
                    if (r_we) begin
                        mem_writedata <= w_merge;
                        mem_we        <= 1'b1;
                        r_state       <= S_WR;
                    end else begin
                        rsp_rdata <= w_load;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_WR: begin
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_lsu
// Purpose  : Directed vector bench for dm_lsu with a synchronous memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic        mem_we;
    logic [31:0] mem_readdata;

    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;
    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_fail = 0;

    dm_lsu dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_we(mem_we), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory with registered read; preload port used only in reset.
    always @(posedge clk) begin
        if (pl_we)       mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_writedata;
        mem_readdata <= mem[mem_addr[7:2]];
    end

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one request and observes until the response (bounded).
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int wes);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; wes = 0; rdata = 32'hX; err = 1'bX;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (rsp_valid) begin
                lat = i; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, wes, nv;
        logic [31:0] d0, d1;

        vecs[0]  = '{"ld_w_8",      1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h00000002, 1'b0, 2, 0};
        vecs[1]  = '{"st_w_8",      1'b1, 2'b10, 1'b0, 32'h08, 32'd42,       32'h00000000, 1'b0, 1, 1};
        vecs[2]  = '{"ld_w_8b",     1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'd42,       1'b0, 2, 0};
        vecs[3]  = '{"st_b_11",     1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h00000000, 1'b0, 3, 1};
        vecs[4]  = '{"ld_w_10",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1122AB44, 1'b0, 2, 0};
        vecs[5]  = '{"ld_bs_11",    1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0};
        vecs[6]  = '{"ld_bu_11",    1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'h000000AB, 1'b0, 2, 0};
        vecs[7]  = '{"ld_hs_12",    1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00001122, 1'b0, 2, 0};
        vecs[8]  = '{"st_h_12",     1'b1, 2'b01, 1'b0, 32'h12, 32'h00008000, 32'h00000000, 1'b0, 3, 1};
        vecs[9]  = '{"ld_hs_12b",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF8000, 1'b0, 2, 0};
        vecs[10] = '{"ld_w_10b",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8000AB44, 1'b0, 2, 0};
        vecs[11] = '{"ld_w_0a_err", 1'b0, 2'b10, 1'b0, 32'h0A, 32'h0,        32'h00000000, 1'b1, 0, 0};
        vecs[12] = '{"st_h_13_err", 1'b1, 2'b01, 1'b0, 32'h13, 32'h1234,     32'h00000000, 1'b1, 0, 0};
        vecs[13] = '{"size11_err",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1, 0, 0};
        vecs[14] = '{"ld_bu_13",    1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0, 2, 0};
        vecs[15] = '{"st_b_10",     1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFFFF5A, 32'h00000000, 1'b0, 3, 1};
        vecs[16] = '{"ld_hu_10",    1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h0000AB5A, 1'b0, 2, 0};

        // Preload while reset is held.
        @(negedge clk); pl_we = 1'b1; pl_idx = 6'd2; pl_data = 32'h00000002;
        @(negedge clk); pl_idx = 6'd4; pl_data = 32'h11223344;
        @(negedge clk); pl_we = 1'b0;
        check("rst_ready",  {31'b0, req_ready}, 32'h1);
        check("rst_rvalid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rdata",  rsp_rdata, 32'h0);
        check("rst_err",    {31'b0, rsp_err}, 32'h0);
        check("rst_maddr",  mem_addr, 32'h0);
        check("rst_mwdata", mem_writedata, 32'h0);
        check("rst_mwe",    {31'b0, mem_we}, 32'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            do_req(vecs[k].we, vecs[k].size, vecs[k].sgn, vecs[k].addr, vecs[k].wdata,
                   rd, er, lat, wes);
            check({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rdata);
            check({vecs[k].name, "_err"}, {31'b0, er}, {31'b0, vecs[k].exp_err});
            check({vecs[k].name, "_lat"}, 32'(lat), 32'(vecs[k].exp_lat));
            check({vecs[k].name, "_wes"}, 32'(wes), 32'(vecs[k].exp_wes));
        end
        check("mem_8",  mem[2], 32'd42);
        check("mem_10", mem[4], 32'h8000AB5A);
        // Response data and error hold after the pulse.
        @(negedge clk);
        check("hold_rdata", rsp_rdata, 32'h0000AB5A);
        check("hold_rvalid", {31'b0, rsp_valid}, 32'h0);

        // req_valid held with a changing request while busy.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        nv = 0; wes = 0; d0 = 32'h0; d1 = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (rsp_valid) begin
                nv++;
                if (c == 2) d0 = rsp_rdata;
                if (c == 6) d1 = rsp_rdata;
            end
            if (c < 3) begin
                req_we = 1'b1; req_size = 2'b10; req_addr = 32'h08; req_wdata = 32'hDEAD0000 + 32'(c);
            end else if (c == 3) begin
                req_we = 1'b0; req_size = 2'b10; req_addr = 32'h08; req_wdata = 32'h0;
            end else begin
                req_valid = 1'b0;
            end
        end
        check("busy_nrsp", 32'(nv), 32'd2);
        check("busy_wes",  32'(wes), 32'd0);
        check("busy_rsp0", d0, 32'h8000AB5A);
        check("busy_rsp1", d1, 32'd42);

        // Reset asserted during RDW of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_ready",  {31'b0, req_ready}, 32'h1);
        check("mid_mwe",    {31'b0, mem_we}, 32'h0);
        check("mid_maddr",  mem_addr, 32'h0);
        check("mid_mwdata", mem_writedata, 32'h0);
        nv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid || mem_we) nv++;
        end
        check("mid_quiet", 32'(nv), 32'd0);
        reset = 1'b0;
        check("mid_mem", mem[4], 32'h8000AB5A);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, wes);
        check("post_rdata", rd, 32'h8000AB5A);
        check("post_lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
